// File: rtl/l1_biu_ctrl.sv
// L1 data-cache bus interface responder: turns level-held L1 requests into
// single-beat 64-bit bus transactions and returns completion/error pulses.
module l1_biu_ctrl #(
  parameter int unsigned LINE_BYTES = 1024,
  parameter int unsigned CNT_W      = $clog2(LINE_BYTES) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read_req,
  input  logic             write_through_req,
  input  logic             read_line_req,
  input  logic             write_line_req,
  input  logic [3:0]       L1_size,
  input  logic [63:0]      pa,
  input  logic [63:0]      wt_data,
  output logic [63:0]      line_data,
  output logic [CNT_W-1:0] addr_count,
  output logic             line_write,
  output logic             cache_entry_refill,
  output logic             trans_rdy,
  output logic             bus_error,
  output logic             bus_req,
  output logic             bus_we,
  output logic [63:0]      bus_addr,
  output logic [3:0]       bus_size,
  output logic [63:0]      bus_wdata,
  input  logic [63:0]      bus_rdata,
  input  logic             bus_ack,
  input  logic             bus_err
);

  localparam int unsigned OffW = $clog2(LINE_BYTES);
  localparam logic [CNT_W-1:0] LastOff  = CNT_W'(LINE_BYTES - 8);
  localparam logic [CNT_W-1:0] BeatStep = CNT_W'(8);

  typedef enum logic [2:0] {StIdle, StSingle, StLineRd, StLineWb, StResp, StErr} state_e;

  state_e           state_q, state_d;
  logic             is_write_q, is_write_d;
  logic [CNT_W-1:0] off_q, off_d;
  logic [63:0]      base_q, base_d;
  logic [63:0]      addr_q, addr_d;
  logic [3:0]       size_q, size_d;
  logic             we_q, we_d;
  logic [63:0]      wdata_q, wdata_d;
  logic             req_q, req_d;
  logic [63:0]      line_data_q, line_data_d;
  logic [CNT_W-1:0] addr_count_q, addr_count_d;
  logic             line_write_q, line_write_d;
  logic             refill_q, refill_d;
  logic             rdy_q, rdy_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] nxt_off;
  logic [63:0]      nxt_addr;
  logic [63:0]      pa_base;

  assign nxt_off  = off_q + BeatStep;
  // Offset stays below LINE_BYTES, so OR-ing never carries into the tag bits.
  assign nxt_addr = base_q | 64'(nxt_off);
  assign pa_base  = {pa[63:OffW], {OffW{1'b0}}};

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    is_write_d   = is_write_q;
    off_d        = off_q;
    base_d       = base_q;
    addr_d       = addr_q;
    size_d       = size_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    req_d        = req_q;
    line_data_d  = line_data_q;
    addr_count_d = addr_count_q;
    line_write_d = 1'b0;
    refill_d     = 1'b0;
    rdy_d        = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (read_line_req || write_line_req || read_req || write_through_req) begin
          base_d       = pa_base;
          off_d        = '0;
          addr_count_d = '0;
          wdata_d      = wt_data;
          req_d        = 1'b1;
          if (read_line_req || write_line_req) begin
            state_d = read_line_req ? StLineRd : StLineWb;
            we_d    = !read_line_req;
            size_d  = 4'b1000;
            addr_d  = pa_base;
          end else begin
            state_d    = StSingle;
            is_write_d = !read_req;
            we_d       = !read_req;
            size_d     = L1_size;
            addr_d     = pa;
          end
        end
      end
      StSingle: begin
        if (bus_err) begin
          state_d = StErr;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else if (bus_ack) begin
          state_d = StResp;
          req_d   = 1'b0;
          rdy_d   = 1'b1;
          if (!is_write_q) line_data_d = bus_rdata;
        end
      end
      StLineRd: begin
        if (bus_err) begin
          state_d = StErr;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else if (bus_ack) begin
          line_write_d = 1'b1;
          line_data_d  = bus_rdata;
          addr_count_d = off_q;
          if (off_q == LastOff) begin
            state_d  = StResp;
            req_d    = 1'b0;
            rdy_d    = 1'b1;
            refill_d = 1'b1;
            off_d    = '0;
          end else begin
            off_d  = nxt_off;
            addr_d = nxt_addr;
          end
        end
      end
      StLineWb: begin
        if (bus_err) begin
          state_d = StErr;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else if (bus_ack) begin
          if (off_q == LastOff) begin
            state_d = StResp;
            req_d   = 1'b0;
            rdy_d   = 1'b1;
            off_d   = '0;
          end else begin
            off_d        = nxt_off;
            addr_count_d = nxt_off;
            addr_d       = nxt_addr;
          end
        end
      end
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      is_write_q   <= 1'b0;
      off_q        <= '0;
      base_q       <= '0;
      addr_q       <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      req_q        <= 1'b0;
      line_data_q  <= '0;
      addr_count_q <= '0;
      line_write_q <= 1'b0;
      refill_q     <= 1'b0;
      rdy_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_write_q   <= is_write_d;
      off_q        <= off_d;
      base_q       <= base_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      req_q        <= req_d;
      line_data_q  <= line_data_d;
      addr_count_q <= addr_count_d;
      line_write_q <= line_write_d;
      refill_q     <= refill_d;
      rdy_q        <= rdy_d;
      err_q        <= err_d;
    end
  end

  assign line_data          = line_data_q;
  assign addr_count         = addr_count_q;
  assign line_write         = line_write_q;
  assign cache_entry_refill = refill_q;
  assign trans_rdy          = rdy_q;
  assign bus_error          = err_q;
  assign bus_req            = req_q;
  assign bus_we             = we_q;
  assign bus_addr           = addr_q;
  assign bus_size           = size_q;
  // Write-back data follows the L1's beat selected by addr_count.
  assign bus_wdata          = (state_q == StLineWb) ? wt_data : wdata_q;

endmodule

// File: tb/tb_l1_biu_ctrl.sv
// Directed bench for l1_biu_ctrl with a 64-byte line (8 beats).
module tb_l1_biu_ctrl;
  localparam int unsigned LB = 64;
  localparam int unsigned CW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          read_req, write_through_req, read_line_req, write_line_req;
  logic [3:0]    L1_size;
  logic [63:0]   pa, wt_data;
  logic [63:0]   line_data;
  logic [CW-1:0] addr_count;
  logic          line_write, cache_entry_refill, trans_rdy, bus_error;
  logic          bus_req, bus_we;
  logic [63:0]   bus_addr, bus_wdata, bus_rdata;
  logic [3:0]    bus_size;
  logic          bus_ack, bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  l1_biu_ctrl #(.LINE_BYTES(LB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .read_req(read_req), .write_through_req(write_through_req),
    .read_line_req(read_line_req), .write_line_req(write_line_req),
    .L1_size(L1_size), .pa(pa), .wt_data(wt_data),
    .line_data(line_data), .addr_count(addr_count), .line_write(line_write),
    .cache_entry_refill(cache_entry_refill), .trans_rdy(trans_rdy), .bus_error(bus_error),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_size(bus_size),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [63:0] pa;
    logic [3:0]  size;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          waits;
    logic [63:0] exp_addr;
    logic [3:0]  exp_size;
    logic        exp_we;
    logic [63:0] exp_wdata;
    logic [63:0] exp_line_data;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%b required=%b", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rd_pat(input int b);
    return 64'hD00D_F00D_0000_0000 + 64'(b);
  endfunction

  function automatic logic [63:0] wb_pat(input int b);
    return 64'hB00B_0000_0000_0000 + 64'(b) * 64'h10;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_line_data"}, line_data, 64'h0);
    chk({tag, "_addr_count"}, 64'(addr_count), 64'h0);
    chk1({tag, "_line_write"}, line_write, 1'b0);
    chk1({tag, "_refill"}, cache_entry_refill, 1'b0);
    chk1({tag, "_trans_rdy"}, trans_rdy, 1'b0);
    chk1({tag, "_bus_error"}, bus_error, 1'b0);
    chk1({tag, "_bus_req"}, bus_req, 1'b0);
    chk1({tag, "_bus_we"}, bus_we, 1'b0);
    chk({tag, "_bus_addr"}, bus_addr, 64'h0);
    chk({tag, "_bus_size"}, 64'(bus_size), 64'h0);
    chk({tag, "_bus_wdata"}, bus_wdata, 64'h0);
  endtask

  task automatic run_single(input vec_t v);
    read_req          = !v.is_wr;
    write_through_req = v.is_wr;
    pa      = v.pa;
    L1_size = v.size;
    wt_data = v.wdata;
    step();
    chk1("single_bus_req", bus_req, 1'b1);
    chk("single_bus_addr", bus_addr, v.exp_addr);
    chk("single_bus_size", 64'(bus_size), 64'(v.exp_size));
    chk1("single_bus_we", bus_we, v.exp_we);
    if (v.is_wr) chk("single_bus_wdata", bus_wdata, v.exp_wdata);
    for (int w = 0; w < v.waits; w++) begin
      step();
      chk1("single_wait_req", bus_req, 1'b1);
      chk1("single_wait_rdy", trans_rdy, 1'b0);
      chk("single_wait_addr", bus_addr, v.exp_addr);
    end
    bus_ack   = 1'b1;
    bus_rdata = v.rdata;
    step();
    bus_ack   = 1'b0;
    bus_rdata = 64'h0;
    chk1("single_trans_rdy", trans_rdy, 1'b1);
    chk1("single_req_low", bus_req, 1'b0);
    chk1("single_no_error", bus_error, 1'b0);
    chk1("single_no_lw", line_write, 1'b0);
    if (!v.is_wr) chk("single_line_data", line_data, v.exp_line_data);
    read_req          = 1'b0;
    write_through_req = 1'b0;
    step();
    chk1("single_rdy_pulse", trans_rdy, 1'b0);
  endtask

  task automatic line_read(input logic [63:0] pa_v, input bit stall, input int err_beat,
                           input bit also_single);
    logic [63:0] base;
    int beat, lw_cnt, refills, done_c;
    bit done;
    base    = pa_v & ~64'(LB - 1);
    beat    = 0;
    lw_cnt  = 0;
    refills = 0;
    done    = 1'b0;
    done_c  = -1;
    read_line_req = 1'b1;
    read_req      = also_single;
    pa            = pa_v;
    L1_size       = 4'b0001;
    step();
    for (int c = 0; c < 400; c++) begin
      if (line_write) begin
        chk("lw_data", line_data, rd_pat(lw_cnt));
        chk("lw_offset", 64'(addr_count), 64'(lw_cnt * 8));
        lw_cnt++;
      end
      if (cache_entry_refill) refills++;
      if (trans_rdy || bus_error) begin
        done   = 1'b1;
        done_c = c;
        break;
      end
      if (bus_req) begin
        chk("line_bus_addr", bus_addr, base + 64'(beat * 8));
        chk("line_bus_size", 64'(bus_size), 64'h8);
        chk1("line_bus_we", bus_we, 1'b0);
        if (beat == err_beat) begin
          bus_err = 1'b1;
          bus_ack = 1'b1;
        end else if (stall && ($urandom_range(0, 2) == 0)) begin
          bus_ack = 1'b0;
        end else begin
          bus_ack   = 1'b1;
          bus_rdata = rd_pat(beat);
          beat++;
        end
      end
      step();
      bus_ack = 1'b0;
      bus_err = 1'b0;
    end
    chk1("line_done", done, 1'b1);
    if (err_beat < 0) begin
      chk1("line_trans_rdy", trans_rdy, 1'b1);
      chk1("line_refill_with_rdy", cache_entry_refill, 1'b1);
      chk1("line_no_error", bus_error, 1'b0);
      chk("line_refill_pulses", 64'(refills), 64'd1);
      chk("line_lw_count", 64'(lw_cnt), 64'd8);
      if (!stall) chk("line_latency", 64'(done_c), 64'd8);
    end else begin
      chk1("err_bus_error", bus_error, 1'b1);
      chk1("err_no_rdy", trans_rdy, 1'b0);
      chk1("err_req_low", bus_req, 1'b0);
      chk("err_refills", 64'(refills), 64'd0);
      chk("err_lw_count", 64'(lw_cnt), 64'(err_beat));
    end
    read_line_req = 1'b0;
    read_req      = 1'b0;
    step();
    chk1("line_after_lw", line_write, 1'b0);
    chk1("line_after_rdy", trans_rdy, 1'b0);
    chk1("line_after_err", bus_error, 1'b0);
    chk1("line_after_refill", cache_entry_refill, 1'b0);
  endtask

  task automatic line_wb(input logic [63:0] pa_v, input bit stall);
    logic [63:0] base;
    int beat;
    bit done;
    base = pa_v & ~64'(LB - 1);
    beat = 0;
    done = 1'b0;
    write_line_req = 1'b1;
    pa             = pa_v;
    wt_data        = wb_pat(0);
    step();
    for (int c = 0; c < 400; c++) begin
      if (trans_rdy || bus_error) begin
        done = 1'b1;
        break;
      end
      wt_data = wb_pat(beat);
      #1;
      if (bus_req) begin
        chk("wb_addr_count", 64'(addr_count), 64'(beat * 8));
        chk("wb_bus_wdata", bus_wdata, wb_pat(beat));
        chk("wb_bus_addr", bus_addr, base + 64'(beat * 8));
        chk1("wb_bus_we", bus_we, 1'b1);
        chk("wb_bus_size", 64'(bus_size), 64'h8);
        if (!(stall && ($urandom_range(0, 2) == 0))) begin
          bus_ack = 1'b1;
          beat++;
        end
      end
      step();
      bus_ack = 1'b0;
    end
    chk1("wb_done", done, 1'b1);
    chk1("wb_trans_rdy", trans_rdy, 1'b1);
    chk1("wb_no_error", bus_error, 1'b0);
    chk1("wb_no_refill", cache_entry_refill, 1'b0);
    chk("wb_beats", 64'(beat), 64'd8);
    write_line_req = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //     is_wr pa                      size     wdata                   rdata
    //     waits exp_addr                exp_size we   exp_wdata               exp_line_data
    vecs[0] = '{1'b0, 64'h0000_0000_8000_0010, 4'b0100, 64'h0, 64'h0000_0000_DEAD_BEEF,
                2, 64'h0000_0000_8000_0010, 4'b0100, 1'b0, 64'h0, 64'h0000_0000_DEAD_BEEF};
    vecs[1] = '{1'b1, 64'h0000_0000_1000_0008, 4'b1000, 64'h1122_3344_5566_7788, 64'h0,
                0, 64'h0000_0000_1000_0008, 4'b1000, 1'b1, 64'h1122_3344_5566_7788, 64'h0};
    vecs[2] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 4'b1000, 64'h0, 64'h0123_4567_89AB_CDEF,
                0, 64'hFFFF_FFFF_FFFF_FFF8, 4'b1000, 1'b0, 64'h0, 64'h0123_4567_89AB_CDEF};
    vecs[3] = '{1'b1, 64'h0000_0000_0000_0003, 4'b0001, 64'h0000_0000_0000_00AB, 64'h0,
                1, 64'h0000_0000_0000_0003, 4'b0001, 1'b1, 64'h0000_0000_0000_00AB, 64'h0};
    vecs[4] = '{1'b0, 64'h0000_0000_1234_5676, 4'b0010, 64'h0, 64'h0000_0000_0000_CAFE,
                0, 64'h0000_0000_1234_5676, 4'b0010, 1'b0, 64'h0, 64'h0000_0000_0000_CAFE};

    rst = 1'b1;
    read_req = 1'b0; write_through_req = 1'b0; read_line_req = 1'b0; write_line_req = 1'b0;
    L1_size = 4'b0; pa = 64'h0; wt_data = 64'h0;
    bus_rdata = 64'h0; bus_ack = 1'b0; bus_err = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    foreach (vecs[i]) run_single(vecs[i]);

    line_read(64'h0000_0000_1234_5678, 1'b0, -1, 1'b0);
    line_read(64'h0000_0000_1234_5678, 1'b1, -1, 1'b0);
    line_read(64'h0000_0000_1234_5678, 1'b0, 3, 1'b0);
    // Next request after an error is accepted normally.
    run_single(vecs[0]);
    // read_req alongside read_line_req: the refill wins.
    line_read(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, -1, 1'b1);
    line_wb(64'h0000_0000_0000_0FC0, 1'b0);
    line_wb(64'h0000_0000_ABCD_0044, 1'b1);

    // Request still held in the trans_rdy cycle must not start a second access.
    read_req = 1'b1; pa = 64'h40; L1_size = 4'b1000;
    step();
    bus_ack = 1'b1; bus_rdata = 64'h55;
    step();
    bus_ack = 1'b0;
    chk1("retrig_rdy", trans_rdy, 1'b1);
    step();
    read_req = 1'b0;
    chk1("retrig_idle_req", bus_req, 1'b0);
    chk1("retrig_rdy_low", trans_rdy, 1'b0);
    step();
    chk1("retrig_not_accepted", bus_req, 1'b0);

    // Reset in the middle of a refill, with an ack in flight.
    read_line_req = 1'b1; pa = 64'h0000_0000_2000_0000;
    step();
    for (int b = 0; b < 3; b++) begin
      bus_ack = 1'b1; bus_rdata = rd_pat(b);
      step();
    end
    chk1("midrst_req_before", bus_req, 1'b1);
    rst = 1'b1; bus_ack = 1'b1;
    step();
    chk_all_zero("midrst");
    rst = 1'b0; read_line_req = 1'b0; bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    chk1("midrst_late_lw", line_write, 1'b0);
    chk1("midrst_late_req", bus_req, 1'b0);
    chk1("midrst_late_rdy", trans_rdy, 1'b0);
    chk1("midrst_late_err", bus_error, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
